// File: rtl/gf180mcu_ocd_io__pwr_seq_pkg.sv
// Shared types and helpers for the pad-ring power-up sequencer.
// State encodings are fixed; they are visible on the STATE debug port.
package gf180mcu_ocd_io__pwr_seq_pkg;

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_RELEASE  = 3'd2,
    ST_ON       = 3'd3,
    ST_FAULT    = 3'd4
  } state_t;

  localparam logic [2:0] ILLEGAL_LO = 3'd5;
  localparam logic [2:0] ILLEGAL_HI = 3'd7;

  function automatic logic in_illegal_range(input logic [2:0] s);
    return ({1'b0, s} >= {1'b0, ILLEGAL_LO}) && ({1'b0, s} <= {1'b0, ILLEGAL_HI});
  endfunction

  // Never returns 0, so a 1-cycle debounce/delay still gets a real counter bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    int w;
    m = (a > b) ? a : b;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/gf180mcu_ocd_io__sync.sv
// N-stage synchroniser for an asynchronous level, synchronous reset to 0.
module gf180mcu_ocd_io__sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [N-1:0] sync_q;
  logic [N-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[N-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[N-1];

endmodule

// File: rtl/gf180mcu_ocd_io__pwr_seq.sv
// Pad-ring power-up sequencer: debounces both supply-OK flags, then releases
// isolation and output-enable in order; any supply loss after release faults.
module gf180mcu_ocd_io__pwr_seq
  import gf180mcu_ocd_io__pwr_seq_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ISO_DELAY       = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       DVDD_OK,
  input  logic       VDD_OK,
  input  logic       FORCE_ISO,
  input  logic       FAULT_CLR,
  output logic       ISO,
  output logic       OE_EN,
  output logic       PWR_GOOD,
  output logic       FAULT,
  output logic [2:0] STATE
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, ISO_DELAY);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ISO_LAST = CNT_W'(ISO_DELAY - 1);

  logic dvdd_ok_s;
  logic vdd_ok_s;
  logic ok;

  gf180mcu_ocd_io__sync #(.N(SYNC_STAGES)) u_sync_dvdd (
    .clk (CLK),
    .rst (RST),
    .d   (DVDD_OK),
    .q   (dvdd_ok_s)
  );

  gf180mcu_ocd_io__sync #(.N(SYNC_STAGES)) u_sync_vdd (
    .clk (CLK),
    .rst (RST),
    .d   (VDD_OK),
    .q   (vdd_ok_s)
  );

  assign ok = dvdd_ok_s & vdd_ok_s;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             force_q, force_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    force_d = FORCE_ISO;
    if (in_illegal_range(state_q)) begin
      state_d = ST_FAULT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          cnt_d = '0;
          if (ok) state_d = ST_DEBOUNCE;
        end
        ST_DEBOUNCE: begin
          if (!ok) begin
            state_d = ST_OFF;
            cnt_d   = '0;
          end else if (cnt_q == DEB_LAST) begin
            state_d = ST_RELEASE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        // Supply loss takes priority over the terminal count.
        ST_RELEASE: begin
          if (!ok) begin
            state_d = ST_FAULT;
            cnt_d   = '0;
          end else if (cnt_q == ISO_LAST) begin
            state_d = ST_ON;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_ON: begin
          cnt_d = '0;
          if (!ok) state_d = ST_FAULT;
        end
        ST_FAULT: begin
          cnt_d = '0;
          if (FAULT_CLR) state_d = ST_OFF;
        end
        default: begin
          state_d = ST_FAULT;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      force_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      force_q <= force_d;
    end
  end

  // Outputs depend only on flops, so they change cleanly right after the edge.
  assign ISO      = force_q || (state_q == ST_OFF) || (state_q == ST_DEBOUNCE) ||
                    (state_q == ST_FAULT);
  assign OE_EN    = (state_q == ST_ON) && !force_q;
  assign PWR_GOOD = (state_q == ST_ON);
  assign FAULT    = (state_q == ST_FAULT);
  assign STATE    = state_q;

endmodule
